xor3_parity_seq: RTL
====================

XOR3_PARITY_SEQ -- requirements
Module: xor3_parity_seq

Interface
REQ-001 Parameter: WIDTH, 8, data word width; SHALL be even and >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to compute parity of data; sampled on clk rising edge.
REQ-005 Port: data  input  WIDTH  word to reduce; sampled only in the cycle start is accepted.
REQ-006 Port: busy  output  1  high while a reduction is in progress.
REQ-007 Port: done  output  1  one-cycle pulse marking parity valid.
REQ-008 Port: parity  output  1  even-parity bit (XOR of all data bits) of the last completed word.

Function
REQ-009 Datapath SHALL instantiate exactly one cmos_xor3 cell, port order (a, b, c, out), shared across all cycles of a reduction; no other XOR logic on the reduction path.
REQ-010 State machine SHALL have three states: IDLE, RUN, DONE.
REQ-011 IDLE: busy=0, done=0; start=1 -> capture data into shift register, clear accumulator to 0, clear pair counter to 0, go to RUN.
REQ-012 RUN: each cycle drive cell a=acc, b=sh[0], c=sh[1]; on edge acc<=out, sh shifts right by 2 with zero fill, counter increments; busy=1.
REQ-013 RUN SHALL last exactly WIDTH/2 cycles; on the edge completing pair WIDTH/2-1, parity<=cell out, FSM -> DONE.
REQ-014 Latency: start sampled at edge E0 -> done=1 and parity valid in the cycle after edge E0+WIDTH/2; busy high between E0 and E0+WIDTH/2.
REQ-015 DONE: done=1, busy=0, lasts one cycle; start=1 in DONE accepted exactly as in IDLE (back-to-back, -> RUN); otherwise -> IDLE.
REQ-016 start while in RUN SHALL be ignored; data changes during RUN SHALL not affect the result.
REQ-017 parity SHALL hold its value from one completion until the next completion; it is not cleared on a new start.
REQ-018 Counter width SHALL be ceil(log2(WIDTH/2))+1 bits; no wrap occurs inside a reduction.

Reset
REQ-019 rst_n low SHALL asynchronously force FSM=IDLE, busy=0, done=0, parity=0, accumulator=0, shift register=0, counter=0.
REQ-020 Reset asserted mid-RUN SHALL abort the reduction with no done pulse; first start after rst_n rises is processed normally.
REQ-021 Release of rst_n SHALL be treated as synchronous to clk; start in the first cycle after release is accepted.

Configuration
REQ-022 Macro XOR3_PARITY_CHECK_EN defined: add ports exp_par input 1 (captured with data on start) and err output 1 (err <= parity_result != exp_par, updated at the same edge as parity, held until next completion, reset 0).
REQ-023 Macro XOR3_PARITY_CHECK_EN undefined: exp_par and err ports absent; all other behaviour identical.

Verification
REQ-024 WIDTH=8, data=8'h00, start 1 cycle -> busy for 4 cycles, done pulse 1 cycle, parity=0.
REQ-025 data=8'hA7 (five ones) -> parity=1 at done; then data=8'hFF -> parity=0; parity holds 1 between the two completions.
REQ-026 start=1 with data=8'h01, then start=1 with data=8'h03 on the 2nd RUN cycle -> second start ignored, single done, parity=1.
REQ-027 start data=8'h01, drop rst_n on the 2nd RUN cycle -> busy=0, done=0, parity=0 immediately; no done afterwards.
REQ-028 start in the DONE cycle with data=8'h07 after a reduction of 8'h00 -> no IDLE gap, second done exactly 5 cycles after first, parity=1.
REQ-029 With XOR3_PARITY_CHECK_EN: data=8'h01, exp_par=0 -> err=1 at done; data=8'h03, exp_par=0 -> err=0.

Source files
------------

// File: rtl/xor3_parity_seq.sv
// xor3_parity_seq: serial even-parity reducer built around a single shared
// three-input XOR cell (cmos_xor3). Each RUN cycle folds two data bits into a
// one-bit accumulator, so a WIDTH-bit word takes WIDTH/2 cycles.
//
// Optional feature: define XOR3_PARITY_CHECK_EN to add an expected-parity
// input (exp_par, captured with data) and an error flag (err) that is updated
// together with parity.
//
// WIDTH must be even and >= 2.

// Three-input XOR cell; behavioural stand-in for the library cell.
module cmos_xor3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic out
);

    // Single-gate reduction of the three inputs.
    assign out = a ^ b ^ c;

endmodule

module xor3_parity_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
`ifdef XOR3_PARITY_CHECK_EN
    input  logic             exp_par,
`endif
    output logic             busy,
    output logic             done,
`ifdef XOR3_PARITY_CHECK_EN
    output logic             err,
`endif
    output logic             parity
);

    localparam int CW = $clog2(WIDTH / 2) + 1;

    localparam logic [CW-1:0] LAST_PAIR = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] sh_q,     sh_d;
    logic             acc_q,    acc_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             parity_q, parity_d;
    logic             xor_out;

`ifdef XOR3_PARITY_CHECK_EN
    logic             exp_q,    exp_d;
    logic             err_q,    err_d;
`endif

    // The only XOR on the reduction path: acc ^ bit0 ^ bit1 each RUN cycle.
    cmos_xor3 u_xor3 (
        .a   (acc_q),
        .b   (sh_q[0]),
        .c   (sh_q[1]),
        .out (xor_out)
    );

    // Next-state and datapath decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latch).
        state_d  = state_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
`ifdef XOR3_PARITY_CHECK_EN
        exp_d    = exp_q;
        err_d    = err_q;
`endif

        case (state_q)
            // DONE accepts a new start exactly like IDLE, giving back-to-back words.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    sh_d    = data;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
`ifdef XOR3_PARITY_CHECK_EN
                    exp_d   = exp_par;
`endif
                end
            end

            // start and data are deliberately ignored while a word is in flight.
            S_RUN: begin
                acc_d = xor_out;
                sh_d  = sh_q >> 2;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_PAIR) begin
                    parity_d = xor_out;
                    state_d  = S_DONE;
`ifdef XOR3_PARITY_CHECK_EN
                    err_d    = (xor_out != exp_q);
`endif
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset clears everything, aborting any reduction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sh_q     <= '0;
            acc_q    <= 1'b0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
`ifdef XOR3_PARITY_CHECK_EN
            exp_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q  <= state_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
`ifdef XOR3_PARITY_CHECK_EN
            exp_q    <= exp_d;
            err_q    <= err_d;
`endif
        end
    end

    // Status flags decode straight from the state register, so reset clears them at once.
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign parity = parity_q;
`ifdef XOR3_PARITY_CHECK_EN
    assign err    = err_q;
`endif

endmodule
